// File: rtl/reg_write_arbiter_if.sv
// Bundle between the two write requesters, the control stall and the register-array write port.
// Handshake: a requester raises valid with stable addr/data and keeps them until ready is seen
// high at a rising edge (valid && ready at the edge is the transfer).
interface reg_write_arbiter_if #(
  parameter int NUM_REGS = 7,
  parameter int DATA_W   = 8
);
  logic                hold;
  logic                req0_valid;
  logic                req0_ready;
  logic [2:0]          req0_addr;
  logic [DATA_W-1:0]   req0_data;
  logic                req1_valid;
  logic                req1_ready;
  logic [2:0]          req1_addr;
  logic [DATA_W-1:0]   req1_data;
  logic [NUM_REGS-1:0] ce;
  logic [DATA_W-1:0]   wdata;
  logic                wr_err;
  logic                grant_id;
  logic [15:0]         wr_count;
  logic [7:0]          err_count;

  modport master (
    output hold, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, ce, wdata, wr_err, grant_id, wr_count, err_count
  );

  modport slave (
    input  hold, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, ce, wdata, wr_err, grant_id, wr_count, err_count
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register array write port: one accepted write per cycle,
// one-hot ce pulse the cycle after acceptance, read-only/out-of-range writes dropped and counted.
module reg_write_arbiter #(
  parameter int                  NUM_REGS = 7,
  parameter int                  DATA_W   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK  = 7'b1000000
) (
  input  logic                clk,
  input  logic                rst,
  reg_write_arbiter_if.slave  bus
);
  localparam int ADDR_W = 3;

  logic                last_grant_q, last_grant_d;
  logic                grant_id_q,   grant_id_d;
  logic [NUM_REGS-1:0] ce_q,         ce_d;
  logic [DATA_W-1:0]   wdata_q,      wdata_d;
  logic                wr_err_q,     wr_err_d;
  logic [15:0]         wr_count_q,   wr_count_d;
  logic [7:0]          err_count_q,  err_count_d;

  logic                ready0, ready1, xfer, sel_id, addr_ok;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NUM_REGS-1:0] onehot;

  // The requester that did not win last time has priority under contention.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (!rst && !bus.hold) begin
      ready0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
      ready1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
    end
  end

  assign xfer     = ready0 || ready1;
  assign sel_id   = ready1;
  assign sel_addr = sel_id ? bus.req1_addr : bus.req0_addr;
  assign sel_data = sel_id ? bus.req1_data : bus.req0_data;

  // Indices with no matching register never set a ce bit and leave addr_ok low.
  always_comb begin
    onehot  = '0;
    addr_ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_addr == ADDR_W'(i)) begin
        onehot[i] = 1'b1;
        addr_ok   = !RO_MASK[i];
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    ce_d         = '0;
    wdata_d      = wdata_q;
    wr_err_d     = 1'b0;
    wr_count_d   = wr_count_q;
    err_count_d  = err_count_q;
    if (xfer) begin
      last_grant_d = sel_id;
      grant_id_d   = sel_id;
      wdata_d      = sel_data;
      if (addr_ok) begin
        ce_d       = onehot;
        wr_count_d = wr_count_q + 16'd1;
      end else begin
        wr_err_d = 1'b1;
        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      ce_q         <= '0;
      wdata_q      <= '0;
      wr_err_q     <= 1'b0;
      wr_count_q   <= '0;
      err_count_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      ce_q         <= ce_d;
      wdata_q      <= wdata_d;
      wr_err_q     <= wr_err_d;
      wr_count_q   <= wr_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.ce         = ce_q;
  assign bus.wdata      = wdata_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.wr_count   = wr_count_q;
  assign bus.err_count  = err_count_q;
endmodule
